// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM states, default width
// and the bit-counter width derivation.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // The counter must be able to hold WIDTH itself, not just WIDTH-1.
    function automatic int cntWidth(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor (x - y - bin) built from a 3-to-8 minterm decoder.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic diff,
    output logic bout
);
    logic [7:0] minterm;

    always_comb begin
        minterm    = '0;
        minterm[0] = ~x & ~y & ~bin;
        minterm[1] = ~x & ~y &  bin;
        minterm[2] = ~x &  y & ~bin;
        minterm[3] = ~x &  y &  bin;
        minterm[4] =  x & ~y & ~bin;
        minterm[5] =  x & ~y &  bin;
        minterm[6] =  x &  y & ~bin;
        minterm[7] =  x &  y &  bin;
    end

    // diff = m1|m2|m4|m7, bout = m1|m2|m3|m7, selected by constant masks.
    assign diff = |(minterm & 8'b1001_0110);
    assign bout = |(minterm & 8'b1000_1110);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes {bout, d} = a - b - bin one bit per cycle, LSB first.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [0:WIDTH-1] a,
    input  logic [0:WIDTH-1] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [0:WIDTH-1] d,
    output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CNT_W = cntWidth(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [0:WIDTH-1] aShift_q;
    logic [0:WIDTH-1] bShift_q;
    logic [0:WIDTH-1] result_q;
    logic             borrow_q;
    logic             busy_q;
    logic             done_q;
    logic [0:WIDTH-1] d_q;
    logic             bout_q;
    logic             cellDiff;
    logic             cellBorrow;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             aSign_q;
    logic             bSign_q;
    logic             ovf_q;
`endif

    full_subtractor u_cell (
        .x    (aShift_q[0]),
        .y    (bShift_q[0]),
        .bin  (borrow_q),
        .diff (cellDiff),
        .bout (cellBorrow)
    );

    // Index 0 is the LSB, so operands drain toward index 0 while the result fills from the MSB end.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            aShift_q <= '0;
            bShift_q <= '0;
            result_q <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            d_q      <= '0;
            bout_q   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            aSign_q  <= 1'b0;
            bSign_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        aShift_q <= a;
                        bShift_q <= b;
                        borrow_q <= bin;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= SHIFT;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        aSign_q  <= a[WIDTH-1];
                        bSign_q  <= b[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    aShift_q <= {aShift_q[1:WIDTH-1], 1'b0};
                    bShift_q <= {bShift_q[1:WIDTH-1], 1'b0};
                    result_q <= {result_q[1:WIDTH-1], cellDiff};
                    borrow_q <= cellBorrow;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    d_q     <= result_q;
                    bout_q  <= borrow_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    ovf_q   <= (aSign_q ^ bSign_q) & (result_q[WIDTH-1] ^ aSign_q);
`endif
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): vector table, corner sequences
// and a random back-to-back run, all checked through an expected-result queue.
module tb_serial_subtractor;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] expD;
        logic         expBout;
        logic         expOvf;
    } vector_t;

    typedef struct {
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
    } expect_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [0:W-1] a;
    logic [0:W-1] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [0:W-1] d;
    logic         bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         ovf;
`endif

    int      errors = 0;
    int      checks = 0;
    int      doneCount = 0;
    bit      holdOn = 0;
    bit      donePrev = 0;
    logic [W-1:0] lastD = '0;
    logic    lastBout = 1'b0;
    expect_t sb[$];
    vector_t vec[10];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ports use ascending ranges with index 0 as LSB, so values are mapped bit by bit.
    function automatic logic [0:W-1] toPort(input logic [W-1:0] v);
        logic [0:W-1] p;
        for (int i = 0; i < W; i++) p[i] = v[i];
        return p;
    endfunction

    function automatic logic [W-1:0] fromPort(input logic [0:W-1] p);
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = p[i];
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives operands with a one-cycle start pulse; returns at the negedge after the capture edge.
    task automatic applyStimulus(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin,
                                 input expect_t e, input bit doPush);
        a     = toPort(va);
        b     = toPort(vb);
        bin   = vbin;
        start = 1'b1;
        if (doPush) sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d results still pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    function automatic expect_t model(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin);
        expect_t    e;
        logic [W:0] r;
        r      = {1'b0, va} - {1'b0, vb} - {{W{1'b0}}, vbin};
        e.d    = r[W-1:0];
        e.bout = r[W];
        e.ovf  = (va[W-1] ^ vb[W-1]) & (r[W-1] ^ va[W-1]);
        return e;
    endfunction

    // Scoreboard side: every done pops one expected result; outputs must hold otherwise.
    always @(negedge clk) begin
        expect_t e;
        if (done) begin
            doneCount++;
            checkOutput("donePulseWidth", {31'd0, donePrev}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedDone: done high with no pending result at %0t", $time);
            end else begin
                e = sb.pop_front();
                checkOutput("resultD", {24'd0, fromPort(d)}, {24'd0, e.d});
                checkOutput("resultBout", {31'd0, bout}, {31'd0, e.bout});
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                checkOutput("resultOvf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
            end
        end else if (holdOn) begin
            checkOutput("holdResult", {23'd0, bout, fromPort(d)}, {23'd0, lastBout, lastD});
        end
        donePrev = done;
        lastD    = fromPort(d);
        lastBout = bout;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        expect_t e;
        int      lat;
        int      busyCnt;
        int      doneBefore;
        int      seen;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic    rbin;

        vec[0] = '{8'h04, 8'h02, 1'b0, 8'h02, 1'b0, 1'b0};
        vec[1] = '{8'h02, 8'h04, 1'b0, 8'hFE, 1'b1, 1'b0};
        vec[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vec[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vec[4] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vec[5] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
        vec[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vec[7] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
        vec[8] = '{8'hC8, 8'h64, 1'b1, 8'h63, 1'b0, 1'b1};
        vec[9] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};

        rst   = 1'b1;
        start = 1'b1;
        a     = toPort(8'hAA);
        b     = toPort(8'h55);
        bin   = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("resetBusy", {31'd0, busy}, 32'd0);
        checkOutput("resetDone", {31'd0, done}, 32'd0);
        checkOutput("resetD", {24'd0, fromPort(d)}, 32'd0);
        checkOutput("resetBout", {31'd0, bout}, 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        holdOn = 1'b1;

        // Table vectors with latency and busy-length measurement.
        for (int i = 0; i < 10; i++) begin
            e.d = vec[i].expD; e.bout = vec[i].expBout; e.ovf = vec[i].expOvf;
            applyStimulus(vec[i].a, vec[i].b, vec[i].bin, e, 1'b1);
            lat = 1;
            busyCnt = 0;
            while (!done && lat < 40) begin
                if (busy) busyCnt++;
                @(negedge clk);
                lat++;
            end
            checkOutput("latency", lat, W + 2);
            checkOutput("busyCycles", busyCnt, W + 1);
            checkOutput("busyAtDone", {31'd0, busy}, 32'd0);
            @(negedge clk);
            checkOutput("doneLow", {31'd0, done}, 32'd0);
        end

        // A second start during SHIFT must be ignored.
        doneBefore = doneCount;
        e.d = 8'h04; e.bout = 1'b0; e.ovf = 1'b0;
        applyStimulus(8'h05, 8'h01, 1'b0, e, 1'b1);
        repeat (2) @(negedge clk);
        a     = toPort(8'h09);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDrain(30);
        repeat (W + 4) @(negedge clk);
        checkOutput("ignoredStartDones", doneCount - doneBefore, 1);

        // Reset during the fourth SHIFT cycle aborts the operation.
        e.d = 8'h00; e.bout = 1'b0; e.ovf = 1'b0;
        applyStimulus(8'h33, 8'h11, 1'b0, e, 1'b0);
        repeat (3) @(negedge clk);
        holdOn = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abortBusy", {31'd0, busy}, 32'd0);
        checkOutput("abortDone", {31'd0, done}, 32'd0);
        checkOutput("abortD", {24'd0, fromPort(d)}, 32'd0);
        checkOutput("abortBout", {31'd0, bout}, 32'd0);
        seen = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        checkOutput("abortNoDone", seen, 0);
        holdOn = 1'b1;
        e.d = 8'hFE; e.bout = 1'b0; e.ovf = 1'b0;
        applyStimulus(8'hFF, 8'h01, 1'b0, e, 1'b1);
        waitDrain(30);
        @(negedge clk);

        // Random back-to-back run with start held high.
        doneBefore = doneCount;
        for (int n = 0; n < 1000; n++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom_range(0, 1));
            a    = toPort(ra);
            b    = toPort(rb);
            bin  = rbin;
            start = 1'b1;
            sb.push_back(model(ra, rb, rbin));
            repeat (W + 2) @(negedge clk);
        end
        start = 1'b0;
        waitDrain(30);
        repeat (W + 4) @(negedge clk);
        checkOutput("randomDoneCount", doneCount - doneBefore, 1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request to begin a subtraction; sampled only when not busy.
REQ-005 Port: a  input  [0:WIDTH-1]  minuend; bit 0 is LSB.
REQ-006 Port: b  input  [0:WIDTH-1]  subtrahend; bit 0 is LSB.
REQ-007 Port: bin  input  1  borrow-in, subtracted at bit 0.
REQ-008 Port: busy  output  1  high while a subtraction is in progress.
REQ-009 Port: done  output  1  one-cycle pulse when d/bout become valid.
REQ-010 Port: d  output  [0:WIDTH-1]  difference a - b - bin, modulo 2^WIDTH.
REQ-011 Port: bout  output  1  borrow out of the MSB; high when a < b + bin (unsigned).

Function
REQ-012 FSM SHALL have exactly three states: IDLE, SHIFT, FIN.
REQ-013 IDLE with start=1: capture a, b, bin into internal shift registers, clear bit counter, go to SHIFT.
REQ-014 SHIFT: each cycle, process one bit LSB-first through the full-subtractor cell, shift the difference bit into the result register from the MSB end, register the cell's borrow as the next borrow-in, and increment the counter.
REQ-015 SHIFT SHALL last exactly WIDTH cycles, then go to FIN.
REQ-016 FIN: load d and bout from the result register and final borrow, assert done for one cycle, then go to IDLE.
REQ-017 Latency: start sampled at edge N gives done high in the cycle after edge N+WIDTH+1; d/bout update at that same edge.
REQ-018 busy SHALL be high in SHIFT and FIN, and low in IDLE.
REQ-019 start while busy SHALL be ignored; operand inputs are don't-care after capture.
REQ-020 start held high continuously SHALL begin a new operation on the first IDLE cycle after each FIN.
REQ-021 d and bout SHALL hold their last value from FIN until the next FIN; they SHALL NOT change during SHIFT.
REQ-022 Arithmetic: {bout, d} SHALL equal the (WIDTH+1)-bit two's-complement result of a - b - bin, with bout as the sign/borrow.

Reset
REQ-023 rst=1 at any edge SHALL force IDLE, clear the counter, shift registers and internal borrow, and set busy=0, done=0, d=0, bout=0.
REQ-024 rst asserted mid-SHIFT SHALL abort the operation; no done pulse SHALL follow.
REQ-025 rst has priority over start in the same cycle.

Configuration
REQ-026 Macro SERIAL_SUBTRACTOR_OVF_EN SHALL gate the signed-overflow feature.
REQ-027 With the macro defined: add output port ovf (1 bit); it is set in FIN when the operand signs differ and the sign of d differs from the sign of a; it is cleared by reset; it holds like d.
REQ-028 Without the macro: no ovf port and no overflow logic; all other behaviour is identical.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (IDLE/SHIFT/FIN), the default WIDTH constant and the counter-width derivation.
REQ-030 One sub-module full_subtractor (x, y, bin -> diff, bout) SHALL be instantiated once, built from a 3-to-8 minterm decoder: diff = m1|m2|m4|m7 and bout = m1|m2|m3|m7.
REQ-031 The bit counter width SHALL be clog2(WIDTH+1); no other arithmetic operators are permitted in the datapath.

Verification
REQ-032 a=4, b=2, bin=0, start pulse -> done after WIDTH+1 cycles, d=8'h02, bout=0, busy high for 9 cycles.
REQ-033 a=2, b=4, bin=0 -> d=8'hFE, bout=1; a=0, b=0, bin=1 -> d=8'hFF, bout=1.
REQ-034 start re-pulsed with a=9 during SHIFT of a=5, b=1 -> result d=8'h04, single done pulse, second start ignored.
REQ-035 rst asserted on the 4th SHIFT cycle -> busy=0, d=0, bout=0 next cycle, no done pulse; a following start with a=8'hFF, b=8'h01 -> d=8'hFE, bout=0.
REQ-036 With SERIAL_SUBTRACTOR_OVF_EN: a=8'h80, b=8'h01 -> d=8'h7F, ovf=1, bout=0; a=8'h05, b=8'h03 -> ovf=0.
REQ-037 Random back-to-back run (start held high, 1000 operand pairs) -> every {bout,d} matches the reference a-b-bin model, with exactly one done per operation.
